v810_dmem_resp: RTL and testbench

Data-bus responder for the `v810_exec` core: the memory-side end of the DA/DD/BEn/MRQn/RW protocol. It decodes requests in one address window and serves them from an internal word-wide memory, with byte-lane writes and a programmable number of wait states. It completes each access with a one-cycle READYn acknowledge. It replaces the zero-wait behavioural RAM in benches and is the synthesizable data memory for the core.

---
 rtl/v810_dmem_resp.sv | 115 +++++++++++
 tb/tb_v810_dmem_resp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/v810_dmem_resp.sv
// Memory-side responder for the v810 DA/DD/BEn/MRQn/RW bus: one address window,
// word-wide internal memory, byte-lane writes, fixed wait states, one-cycle READYn ack.
module v810_dmem_resp #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          WAIT = 0
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] DA,
  input  logic [31:0] DD_O,
  input  logic [3:0]  BEn,
  input  logic        MRQn,
  input  logic        RW,
  output logic [31:0] DD_I,
  output logic        READYn,
  output logic        BUSY
);

  // state  | meaning
  // IDLE   | waiting for an in-window request
  // WAITST | counting down wait states
  // ACK    | READYn low for one CE cycle, read data on DD_I
  typedef enum logic [1:0] {IDLE, WAITST, ACK} state_t;

  if (WAIT < 0 || WAIT > 15) begin : g_wait_range
    $error("v810_dmem_resp: WAIT must be 0..15");
  end

  localparam logic [3:0] WAIT_LD = 4'(WAIT);

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [0:(1<<AW)-1];

  logic          hit, accept, enter_ack;
  logic [AW-1:0] addr_eff;
  logic          rw_eff;
  logic [3:0]    be_eff;
  logic [31:0]   wdata_eff;
  logic          unused_da;

  assign unused_da = ^DA[1:0];
  assign hit       = (DA[31:AW+2] == BASE[31:AW+2]);
  assign accept    = (state == IDLE) && !MRQn && hit;

  // With WAIT=0 the access is accepted and enters ACK on the same edge,
  // so the live bus values are used in IDLE and the latched copies after.
  assign addr_eff  = (state == IDLE) ? DA[AW+1:2] : addr_q;
  assign rw_eff    = (state == IDLE) ? RW         : rw_q;
  assign be_eff    = (state == IDLE) ? BEn        : be_q;
  assign wdata_eff = (state == IDLE) ? DD_O       : wdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = WAIT_LD;
          state_nx = (WAIT == 0) ? ACK : WAITST;
        end
      end
      WAITST: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = ACK;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_ack = (state_nx == ACK);

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      be_q    <= 4'hF;
      wdata_q <= 32'h0;
      DD_I    <= 32'h0;
      READYn  <= 1'b1;
      BUSY    <= 1'b0;
    end else if (CE) begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      READYn <= !enter_ack;
      BUSY   <= (state_nx != IDLE);
      DD_I   <= (enter_ack && rw_eff) ? mem[addr_eff] : 32'h0;
      if (accept) begin
        addr_q  <= DA[AW+1:2];
        rw_q    <= RW;
        be_q    <= BEn;
        wdata_q <= DD_O;
      end
    end
  end

  // Memory is not reset; RESn still blocks the write so an aborted access never commits.
  always_ff @(posedge CLK) begin
    if (RESn && CE && enter_ack && !rw_eff) begin
      for (int i = 0; i < 4; i++) begin
        if (!be_eff[i]) mem[addr_eff][8*i +: 8] <= wdata_eff[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_v810_dmem_resp.sv
// Scoreboard bench for v810_dmem_resp: two responders (zero-wait at 0x0, three-wait at 0x1000)
// share one bus; a word-array model predicts every ack, monitors pop and compare.
module tb_v810_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic [31:0] da = 32'h0;
  logic [31:0] dd_o = 32'h0;
  logic [3:0]  ben = 4'hF;
  logic        mreq = 1'b1;
  logic        rw = 1'b1;
  logic [31:0] dd0, dd1;
  logic        rdy0, rdy1, busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ce_mode  = 0;

  logic [31:0] model [2][64];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] e0, e1;

  v810_dmem_resp #(.AW(6), .BASE(32'h0000_0000), .WAIT(0)) dut0 (
    .CLK(clk), .RESn(rst_n), .CE(ce), .DA(da), .DD_O(dd_o), .BEn(ben),
    .MRQn(mreq), .RW(rw), .DD_I(dd0), .READYn(rdy0), .BUSY(busy0)
  );

  v810_dmem_resp #(.AW(6), .BASE(32'h0000_1000), .WAIT(3)) dut1 (
    .CLK(clk), .RESn(rst_n), .CE(ce), .DA(da), .DD_O(dd_o), .BEn(ben),
    .MRQn(mreq), .RW(rw), .DD_I(dd1), .READYn(rdy1), .BUSY(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ce_mode: 0 = always on, 1 = toggle every cycle, 2 = random
  always @(posedge clk) begin
    #2;
    case (ce_mode)
      1:       ce = ~ce;
      2:       ce = 1'($urandom_range(0, 1));
      default: ce = 1'b1;
    endcase
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // An ack is consumed on a CE-high edge; DD_I must be zero outside ACK.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!rdy0) begin
        if (ce) begin
          if (exp_q0.size() == 0) chk(1'b0, "ack0_unexpected", dd0, 32'h0);
          else begin
            e0 = exp_q0.pop_front();
            chk(dd0 == e0, "data0", dd0, e0);
          end
        end
      end else chk(dd0 == 32'h0, "idle_dd0", dd0, 32'h0);
      if (!rdy1) begin
        if (ce) begin
          if (exp_q1.size() == 0) chk(1'b0, "ack1_unexpected", dd1, 32'h0);
          else begin
            e1 = exp_q1.pop_front();
            chk(dd1 == e1, "data1", dd1, e1);
          end
        end
      end else chk(dd1 == 32'h0, "idle_dd1", dd1, 32'h0);
    end
  end

  // Called at posedge+1. Returns the cycle at which the ack was seen.
  task automatic access(input logic [31:0] a, input bit rd, input logic [3:0] be,
                        input logic [31:0] d, input bit hold, output int ack_at);
    int s   = (a[31:8] == 24'h10) ? 1 : 0;
    int idx = int'(a[7:2]);
    int lat = 0;
    int exp_lat;
    bit done = 1'b0;
    bit c;
    logic r;
    logic [31:0] e;
    exp_lat = (s == 1) ? 4 : 1;
    if (rd) e = model[s][idx];
    else begin
      for (int i = 0; i < 4; i++)
        if (!be[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
      e = 32'h0;
    end
    if (s == 1) exp_q1.push_back(e); else exp_q0.push_back(e);
    da = a; rw = rd; ben = be; dd_o = d; mreq = 1'b0;
    ack_at = -1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      c = ce;
      r = (s == 1) ? rdy1 : rdy0;
      if (!r && c) begin
        done = 1'b1;
        ack_at = cyc;
      end else begin
        @(posedge clk); #1;
        if (c) lat++;
      end
    end
    if (!done) begin
      chk(1'b0, "ack_timeout", a, 32'h0);
      mreq = 1'b1;
      return;
    end
    chk(lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    r = (s == 1) ? rdy1 : rdy0;
    chk(r == 1'b1, "ack_len", 32'(r), 32'h1);
    if (!hold) mreq = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    logic [31:0] a;
    int s;

    repeat (2) @(negedge clk);
    chk(rdy0 == 1'b1, "rst_ready0", 32'(rdy0), 32'h1);
    chk(rdy1 == 1'b1, "rst_ready1", 32'(rdy1), 32'h1);
    chk(busy0 == 1'b0, "rst_busy0", 32'(busy0), 32'h0);
    chk(busy1 == 1'b0, "rst_busy1", 32'(busy1), 32'h0);
    chk(dd0 == 32'h0, "rst_dd0", dd0, 32'h0);
    chk(dd1 == 32'h0, "rst_dd1", dd1, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 64; w++) begin
      access(32'(w) << 2, 1'b0, 4'h0, $urandom, 1'b0, t1);
      access(32'h1000 | (32'(w) << 2), 1'b0, 4'h0, $urandom, 1'b0, t1);
    end

    access(32'h4, 1'b0, 4'h0, 32'hDEADBEEF, 1'b0, t1);
    access(32'h4, 1'b1, 4'hF, 32'h0, 1'b0, t1);

    access(32'h8, 1'b0, 4'h0, 32'h11223344, 1'b0, t1);
    access(32'h8, 1'b0, 4'b1010, 32'hAABBCCDD, 1'b0, t1);
    access(32'h8, 1'b1, 4'hF, 32'h0, 1'b0, t1);
    access(32'h8, 1'b0, 4'b1111, 32'h55555555, 1'b0, t1);
    access(32'hB, 1'b1, 4'h0, 32'h0, 1'b0, t1);

    access(32'h70, 1'b0, 4'h0, 32'h9, 1'b1, t1);
    access(32'h70, 1'b1, 4'h0, 32'h0, 1'b0, t2);
    chk(t2 - t1 == 2, "b2b_spacing", 32'(t2 - t1), 32'h2);

    ce_mode = 1;
    access(32'h1010, 1'b1, 4'h0, 32'h0, 1'b0, t1);
    access(32'h1014, 1'b0, 4'b0110, 32'hCAFEF00D, 1'b0, t1);
    access(32'h1014, 1'b1, 4'h0, 32'h0, 1'b0, t1);
    ce_mode = 0;

    da = 32'h400; rw = 1'b0; ben = 4'h0; dd_o = 32'hFFFFFFFF; mreq = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk(rdy0 == 1'b1 && rdy1 == 1'b1, "oow_ready", {30'b0, rdy1, rdy0}, 32'h3);
      chk(busy0 == 1'b0 && busy1 == 1'b0, "oow_busy", {30'b0, busy1, busy0}, 32'h0);
    end
    @(posedge clk); #1;
    mreq = 1'b1;
    access(32'h0, 1'b1, 4'h0, 32'h0, 1'b0, t1);
    access(32'h1000, 1'b1, 4'h0, 32'h0, 1'b0, t1);

    access(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, t1);
    da = 32'h1000; rw = 1'b0; ben = 4'h0; dd_o = 32'hFFFFFFFF; mreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(busy1 == 1'b1, "mid_busy", 32'(busy1), 32'h1);
    rst_n = 1'b0;
    #1;
    chk(rdy1 == 1'b1, "abort_ready", 32'(rdy1), 32'h1);
    chk(busy1 == 1'b0, "abort_busy", 32'(busy1), 32'h0);
    mreq = 1'b1;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(32'h1000, 1'b1, 4'h0, 32'h0, 1'b0, t1);

    for (int i = 0; i < 300; i++) begin
      ce_mode = $urandom_range(0, 2);
      s = $urandom_range(0, 1);
      a = ((s == 1) ? 32'h1000 : 32'h0) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      access(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
             (i != 299) && ($urandom_range(0, 1) == 1), t1);
    end
    ce_mode = 0;

    repeat (4) @(posedge clk);
    #1;
    chk(exp_q0.size() == 0, "q0_drained", 32'(exp_q0.size()), 32'h0);
    chk(exp_q1.size() == 0, "q1_drained", 32'(exp_q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
